i2c_init_seq: RTL and testbench

I2C_INIT_SEQ -- requirements
Module: i2c_init_seq

---
 rtl/i2c_seq_pkg.sv | 29 ++
 rtl/i2c_init_seq_if.sv | 21 ++
 rtl/seq_ms_timer.sv | 41 ++++
 rtl/i2c_init_seq.sv | 167 ++++++++++++++++
 tb/tb_i2c_init_seq.sv | 292 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/i2c_seq_pkg.sv
// Shared types and constants for the I2C register-init sequencer.
package i2c_seq_pkg;

   typedef enum logic [3:0] {
      S_IDLE,
      S_FETCH,
      S_DECODE,
      S_ISSUE,
      S_WAIT_ACC,
      S_WAIT_END,
      S_CHECK,
      S_DELAY,
      S_DONE
   } state_t;

   typedef struct packed {
      logic [7:0] regaddr;
      logic [7:0] val;
   } tbl_entry_t;

   localparam logic [15:0] TBL_END  = 16'hFFFF;
   localparam logic [7:0]  OP_DELAY = 8'hFE;

   // Counter width for values 0..n-1, never below one bit.
   function automatic int unsigned cnt_width(input int unsigned n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/i2c_init_seq_if.sv
// Request/response bundle between the init sequencer and an I2C master engine.
interface i2c_init_seq_if;
   logic       I2C_START;
   logic       I2C_READ;
   logic [6:0] I2C_ADDR;
   logic       I2C_WLEN;
   logic [7:0] I2C_WDATA1;
   logic [7:0] I2C_WDATA2;
   logic       I2C_END;
   logic       I2C_ACK;

   modport master (
      output I2C_START, I2C_READ, I2C_ADDR, I2C_WLEN, I2C_WDATA1, I2C_WDATA2,
      input  I2C_END, I2C_ACK
   );

   modport slave (
      input  I2C_START, I2C_READ, I2C_ADDR, I2C_WLEN, I2C_WDATA1, I2C_WDATA2,
      output I2C_END, I2C_ACK
   );
endinterface

// File: rtl/seq_ms_timer.sv
// Millisecond delay: 1 ms tick divider feeding an 8-bit ms down-counter.
module seq_ms_timer
   import i2c_seq_pkg::*;
#(
   parameter int unsigned CLK_FREQ = 50_000_000
) (
   input  logic       i_clk,
   input  logic       i_rst,
   input  logic       i_load,
   input  logic [7:0] i_ms,
   output logic       o_expire_c
);
   localparam int unsigned TICKS   = (CLK_FREQ >= 1000) ? CLK_FREQ / 1000 : 1;
   localparam int unsigned TW      = cnt_width(TICKS);
   // Fetch/decode/issue cycles after expiry are credited to the first ms
   localparam int unsigned PRELOAD = (TICKS > 4) ? 4 : 0;

   logic [TW-1:0] r_tick;
   logic [7:0]    r_ms;
   logic          w_tick_wrap;

   assign w_tick_wrap = (r_tick == TW'(TICKS - 1));
   assign o_expire_c  = (r_ms == 8'd1) && w_tick_wrap;

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_tick <= '0;
         r_ms   <= '0;
      end else if (i_load) begin
         r_tick <= TW'(PRELOAD);
         r_ms   <= i_ms;
      end else if (r_ms != 8'd0) begin
         if (w_tick_wrap) begin
            r_tick <= '0;
            r_ms   <= r_ms - 8'd1;
         end else begin
            r_tick <= r_tick + TW'(1);
         end
      end
   end
endmodule

// File: rtl/i2c_init_seq.sv
// Walks a ROM table of {reg,val} pairs, issuing two-byte I2C writes with retry and ms delays.
module i2c_init_seq
   import i2c_seq_pkg::*;
#(
   parameter int unsigned CLK_Freq  = 50_000_000,
   parameter logic [6:0]  DEV_ADDR  = 7'h39,
   parameter int unsigned MAX_RETRY = 3,
   parameter int unsigned TBL_AW    = 8
) (
   input  logic              CLK,
   input  logic              RESET,
   input  logic              GO,
   output logic [TBL_AW-1:0] TBL_ADDR,
   input  logic [15:0]       TBL_DATA,
   i2c_init_seq_if.master    i2c,
   output logic              BUSY,
   output logic              DONE,
   output logic              FAIL,
   output logic [TBL_AW-1:0] ERR_IDX
);
   localparam int unsigned RW = cnt_width(MAX_RETRY + 1);

   state_t            r_state, w_state_nxt;
   logic              r_go_d;
   logic [TBL_AW-1:0] r_tbl_addr, w_addr_nxt;
   logic [7:0]        r_wd1, r_wd2, w_wd1_nxt, w_wd2_nxt;
   logic              r_start, w_start_nxt;
   logic              r_busy, r_done;
   logic              r_fail, w_fail_nxt;
   logic [TBL_AW-1:0] r_err_idx, w_err_nxt;
   logic [RW-1:0]     r_retry, w_retry_nxt;
   logic              w_go_rise, w_adv, w_tmr_load, w_expire_c;
   tbl_entry_t        w_entry;

   assign w_go_rise = GO & ~r_go_d;
   assign w_entry   = tbl_entry_t'(TBL_DATA);

   seq_ms_timer #(.CLK_FREQ(CLK_Freq)) u_timer (
      .i_clk      (CLK),
      .i_rst      (RESET),
      .i_load     (w_tmr_load),
      .i_ms       (w_entry.val),
      .o_expire_c (w_expire_c)
   );

   always_comb begin
      w_state_nxt = r_state;
      w_addr_nxt  = r_tbl_addr;
      w_wd1_nxt   = r_wd1;
      w_wd2_nxt   = r_wd2;
      w_start_nxt = r_start;
      w_fail_nxt  = r_fail;
      w_err_nxt   = r_err_idx;
      w_retry_nxt = r_retry;
      w_tmr_load  = 1'b0;
      w_adv       = 1'b0;

      case (r_state)
         S_FETCH:  w_state_nxt = S_DECODE;
         S_DECODE: begin
            if (TBL_DATA == TBL_END) begin
               w_state_nxt = S_DONE;
            end else if (w_entry.regaddr == OP_DELAY) begin
               if (w_entry.val == 8'd0) begin
                  w_adv = 1'b1;
               end else begin
                  w_tmr_load  = 1'b1;
                  w_state_nxt = S_DELAY;
               end
            end else begin
               w_wd1_nxt   = w_entry.regaddr;
               w_wd2_nxt   = w_entry.val;
               w_state_nxt = S_ISSUE;
            end
         end
         // Holding off until the master is idle covers a restart mid-transfer
         S_ISSUE: begin
            if (i2c.I2C_END) begin
               w_start_nxt = 1'b1;
               w_state_nxt = S_WAIT_ACC;
            end
         end
         S_WAIT_ACC: begin
            if (!i2c.I2C_END) begin
               w_start_nxt = 1'b0;
               w_state_nxt = S_WAIT_END;
            end
         end
         S_WAIT_END: if (i2c.I2C_END) w_state_nxt = S_CHECK;
         S_CHECK: begin
            if (!i2c.I2C_ACK) begin
               w_retry_nxt = '0;
               w_adv       = 1'b1;
            end else if (r_retry < RW'(MAX_RETRY)) begin
               w_retry_nxt = r_retry + RW'(1);
               w_state_nxt = S_ISSUE;
            end else begin
               w_fail_nxt  = 1'b1;
               if (!r_fail) w_err_nxt = r_tbl_addr;
               w_retry_nxt = '0;
               w_adv       = 1'b1;
            end
         end
         S_DELAY: if (w_expire_c) w_adv = 1'b1;
         default: ;
      endcase

      if (w_adv) begin
         if (&r_tbl_addr) begin
            w_state_nxt = S_DONE;
         end else begin
            w_addr_nxt  = r_tbl_addr + TBL_AW'(1);
            w_state_nxt = S_FETCH;
         end
      end

      if (w_go_rise) begin
         w_state_nxt = S_FETCH;
         w_addr_nxt  = '0;
         w_start_nxt = 1'b0;
         w_fail_nxt  = 1'b0;
         w_err_nxt   = '0;
         w_retry_nxt = '0;
         w_tmr_load  = 1'b0;
      end
   end

   always_ff @(posedge CLK) begin
      if (RESET) begin
         r_state    <= S_IDLE;
         r_go_d     <= 1'b1;
         r_tbl_addr <= '0;
         r_wd1      <= '0;
         r_wd2      <= '0;
         r_start    <= 1'b0;
         r_busy     <= 1'b0;
         r_done     <= 1'b0;
         r_fail     <= 1'b0;
         r_err_idx  <= '0;
         r_retry    <= '0;
      end else begin
         r_state    <= w_state_nxt;
         r_go_d     <= GO;
         r_tbl_addr <= w_addr_nxt;
         r_wd1      <= w_wd1_nxt;
         r_wd2      <= w_wd2_nxt;
         r_start    <= w_start_nxt;
         r_busy     <= (w_state_nxt != S_IDLE) && (w_state_nxt != S_DONE);
         r_done     <= (w_state_nxt == S_DONE);
         r_fail     <= w_fail_nxt;
         r_err_idx  <= w_err_nxt;
         r_retry    <= w_retry_nxt;
      end
   end

   assign TBL_ADDR       = r_tbl_addr;
   assign BUSY           = r_busy;
   assign DONE           = r_done;
   assign FAIL           = r_fail;
   assign ERR_IDX        = r_err_idx;
   assign i2c.I2C_START  = r_start;
   assign i2c.I2C_READ   = 1'b0;
   assign i2c.I2C_ADDR   = DEV_ADDR;
   assign i2c.I2C_WLEN   = 1'b1;
   assign i2c.I2C_WDATA1 = r_wd1;
   assign i2c.I2C_WDATA2 = r_wd2;
endmodule

// File: tb/tb_i2c_init_seq.sv
// Directed bench for i2c_init_seq with a ROM model and a scripted I2C master.
module tb_i2c_init_seq;
   logic        clk = 1'b0;
   logic        rst;
   logic        go;
   logic [2:0]  tbl_addr;
   logic [15:0] tbl_data;
   logic        busy, done, fail;
   logic [2:0]  err_idx;

   i2c_init_seq_if ifc ();

   i2c_init_seq #(
      .CLK_Freq (1_000_000),
      .DEV_ADDR (7'h39),
      .MAX_RETRY(3),
      .TBL_AW   (3)
   ) dut (
      .CLK     (clk),
      .RESET   (rst),
      .GO      (go),
      .TBL_ADDR(tbl_addr),
      .TBL_DATA(tbl_data),
      .i2c     (ifc),
      .BUSY    (busy),
      .DONE    (done),
      .FAIL    (fail),
      .ERR_IDX (err_idx)
   );

   always #5 clk = ~clk;

   int n_vec = 0;
   int n_err = 0;
   int cyc   = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // ROM model: one-cycle read latency
   logic [15:0] rom [0:7];
   always @(posedge clk) tbl_data <= rom[tbl_addr];

   // Scripted I2C master
   logic        m_clr = 1'b1;
   logic        m_mute = 1'b0;
   int          m_len = 4;
   int          nack_idx = -1;
   int          nack_n = 0;
   int          m_cnt = 0;
   logic        i2c_end_r = 1'b1;
   logic        i2c_ack_r = 1'b0;
   int          att [0:7];
   int          xfer_n = 0;
   logic [7:0]  log_w1 [0:31];
   logic [7:0]  log_w2 [0:31];
   int          log_idx [0:31];

   assign ifc.I2C_END = i2c_end_r;
   assign ifc.I2C_ACK = i2c_ack_r;

   always @(posedge clk) begin
      if (m_clr) begin
         xfer_n    <= 0;
         m_cnt     <= 0;
         i2c_end_r <= 1'b1;
         i2c_ack_r <= 1'b0;
         for (int k = 0; k < 8; k++) att[k] <= 0;
      end else if (m_cnt != 0) begin
         m_cnt <= m_cnt - 1;
         if (m_cnt == 1) i2c_end_r <= 1'b1;
      end else if (ifc.I2C_START && i2c_end_r && !m_mute) begin
         i2c_end_r      <= 1'b0;
         m_cnt          <= m_len;
         i2c_ack_r      <= (int'(tbl_addr) == nack_idx) && (att[tbl_addr] < nack_n);
         att[tbl_addr]  <= att[tbl_addr] + 1;
         if (xfer_n < 32) begin
            log_w1[xfer_n]  <= ifc.I2C_WDATA1;
            log_w2[xfer_n]  <= ifc.I2C_WDATA2;
            log_idx[xfer_n] <= int'(tbl_addr);
         end
         xfer_n <= xfer_n + 1;
      end
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      assert (obs === exp)
      else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic set_tbl(input logic [15:0] a, input logic [15:0] b, input logic [15:0] c);
      for (int k = 0; k < 8; k++) rom[k] = 16'hFFFF;
      rom[0] = a;
      rom[1] = b;
      rom[2] = c;
   endtask

   task automatic new_run();
      m_clr = 1'b1;
      @(posedge clk); #1;
      m_clr = 1'b0;
   endtask

   task automatic pulse_go();
      go = 1'b1;
      @(posedge clk); #1;
      go = 1'b0;
   endtask

   task automatic wait_done(input int bound);
      for (int i = 0; i < bound && done !== 1'b1; i++) begin
         @(posedge clk); #1;
      end
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   int t_fetch, t_start, delta;

   initial begin
      rst = 1'b1;
      go  = 1'b0;
      set_tbl(16'h4110, 16'h9803, 16'hFFFF);
      repeat (3) @(posedge clk);
      #1;
      m_clr = 1'b0;

      // Reset state
      chk("rst_busy",  32'(busy), 32'd0);
      chk("rst_done",  32'(done), 32'd0);
      chk("rst_fail",  32'(fail), 32'd0);
      chk("rst_start", 32'(ifc.I2C_START), 32'd0);
      chk("rst_addr",  32'(tbl_addr), 32'd0);
      chk("rst_wd1",   32'(ifc.I2C_WDATA1), 32'd0);
      chk("i2c_addr",  32'(ifc.I2C_ADDR), 32'h39);
      chk("i2c_read",  32'(ifc.I2C_READ), 32'd0);
      chk("i2c_wlen",  32'(ifc.I2C_WLEN), 32'd1);
      rst = 1'b0;
      @(posedge clk); #1;

      // Plain two-entry table, always ACK
      new_run();
      pulse_go();
      chk("run_busy", 32'(busy), 32'd1);
      wait_done(300);
      chk("t1_done",  32'(done), 32'd1);
      chk("t1_fail",  32'(fail), 32'd0);
      chk("t1_busy",  32'(busy), 32'd0);
      chk("t1_xfers", 32'(xfer_n), 32'd2);
      chk("t1_w1_0",  32'(log_w1[0]), 32'h41);
      chk("t1_w2_0",  32'(log_w2[0]), 32'h10);
      chk("t1_w1_1",  32'(log_w1[1]), 32'h98);
      chk("t1_w2_1",  32'(log_w2[1]), 32'h03);
      chk("t1_addr",  32'(tbl_addr), 32'd2);

      // Entry 1 NACKs twice then ACKs
      new_run();
      nack_idx = 1; nack_n = 2;
      pulse_go();
      chk("t2_done_clr", 32'(done), 32'd0);
      wait_done(400);
      chk("t2_att1",  32'(att[1]), 32'd3);
      chk("t2_att0",  32'(att[0]), 32'd1);
      chk("t2_xfers", 32'(xfer_n), 32'd4);
      chk("t2_fail",  32'(fail), 32'd0);
      chk("t2_done",  32'(done), 32'd1);
      chk("t2_last",  32'(log_w1[3]), 32'h98);

      // Entry 0 always NACKs; run continues
      new_run();
      nack_idx = 0; nack_n = 99;
      pulse_go();
      wait_done(500);
      chk("t3_att0",  32'(att[0]), 32'd4);
      chk("t3_att1",  32'(att[1]), 32'd1);
      chk("t3_xfers", 32'(xfer_n), 32'd5);
      chk("t3_fail",  32'(fail), 32'd1);
      chk("t3_err",   32'(err_idx), 32'd0);
      chk("t3_done",  32'(done), 32'd1);

      // Entry 1 always NACKs; GO clears previous FAIL
      new_run();
      nack_idx = 1;
      pulse_go();
      chk("t3b_fail_clr", 32'(fail), 32'd0);
      chk("t3b_done_clr", 32'(done), 32'd0);
      wait_done(500);
      chk("t3b_att1", 32'(att[1]), 32'd4);
      chk("t3b_fail", 32'(fail), 32'd1);
      chk("t3b_err",  32'(err_idx), 32'd1);
      chk("t3b_done", 32'(done), 32'd1);
      nack_idx = -1; nack_n = 0;

      // 5 ms delay entry at 1 MHz
      set_tbl(16'hFE05, 16'h1234, 16'hFFFF);
      new_run();
      pulse_go();
      t_fetch = cyc;
      for (int i = 0; i < 6000 && ifc.I2C_START !== 1'b1; i++) begin
         @(posedge clk); #1;
      end
      t_start = cyc;
      delta = t_start - t_fetch - 1;
      chk("t4_start",  32'(ifc.I2C_START), 32'd1);
      chk("t4_window", 32'((delta >= 4997) && (delta <= 5003)), 32'd1);
      wait_done(200);
      chk("t4_xfers", 32'(xfer_n), 32'd1);
      chk("t4_w1",    32'(log_w1[0]), 32'h12);
      chk("t4_w2",    32'(log_w2[0]), 32'h34);

      // Zero-length delay advances immediately
      set_tbl(16'hFE00, 16'h5566, 16'hFFFF);
      new_run();
      pulse_go();
      wait_done(200);
      chk("t5_xfers", 32'(xfer_n), 32'd1);
      chk("t5_w1",    32'(log_w1[0]), 32'h55);
      chk("t5_w2",    32'(log_w2[0]), 32'h66);
      chk("t5_done",  32'(done), 32'd1);

      // GO re-pulsed while the master is still busy
      set_tbl(16'h4110, 16'h9803, 16'hFFFF);
      new_run();
      m_len = 40;
      pulse_go();
      for (int i = 0; i < 50 && i2c_end_r !== 1'b0; i++) begin
         @(posedge clk); #1;
      end
      repeat (5) @(posedge clk);
      #1;
      pulse_go();
      m_len = 4;
      chk("t6_start", 32'(ifc.I2C_START), 32'd0);
      chk("t6_busy",  32'(busy), 32'd1);
      chk("t6_addr",  32'(tbl_addr), 32'd0);
      repeat (10) @(posedge clk);
      #1;
      chk("t6_hold_start", 32'(ifc.I2C_START), 32'd0);
      chk("t6_hold_xfers", 32'(xfer_n), 32'd1);
      wait_done(400);
      chk("t6_xfers", 32'(xfer_n), 32'd3);
      chk("t6_idx1",  32'(log_idx[1]), 32'd0);
      chk("t6_idx2",  32'(log_idx[2]), 32'd1);
      chk("t6_done",  32'(done), 32'd1);

      // Reset while waiting for acceptance, GO held high through reset
      set_tbl(16'hFE00, 16'h4110, 16'hFFFF);
      new_run();
      m_mute = 1'b1;
      pulse_go();
      for (int i = 0; i < 20 && ifc.I2C_START !== 1'b1; i++) begin
         @(posedge clk); #1;
      end
      chk("t7_acc_start", 32'(ifc.I2C_START), 32'd1);
      go  = 1'b1;
      rst = 1'b1;
      @(posedge clk); #1;
      chk("t7_start", 32'(ifc.I2C_START), 32'd0);
      chk("t7_busy",  32'(busy), 32'd0);
      chk("t7_addr",  32'(tbl_addr), 32'd0);
      chk("t7_wd1",   32'(ifc.I2C_WDATA1), 32'd0);
      chk("t7_wd2",   32'(ifc.I2C_WDATA2), 32'd0);
      rst = 1'b0;
      repeat (10) @(posedge clk);
      #1;
      chk("t7_no_run_start", 32'(ifc.I2C_START), 32'd0);
      chk("t7_no_run_busy",  32'(busy), 32'd0);
      go = 1'b0;
      m_mute = 1'b0;
      @(posedge clk); #1;

      // Table with no sentinel stops at the last index
      for (int k = 0; k < 8; k++) rom[k] = {8'h10 + 8'(k), 8'hA0 + 8'(k)};
      new_run();
      pulse_go();
      wait_done(600);
      chk("t8_xfers", 32'(xfer_n), 32'd8);
      chk("t8_addr",  32'(tbl_addr), 32'd7);
      chk("t8_w1",    32'(log_w1[7]), 32'h17);
      chk("t8_w2",    32'(log_w2[7]), 32'hA7);
      chk("t8_done",  32'(done), 32'd1);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
